// File: rtl/gray_rx_tracker.sv
// Receive side of a Gray-coded count link: synchronizes the incoming code, decodes it
// to binary, reports single-step direction and counts illegal multi-bit transitions.
module gray_rx_tracker #(
    parameter int BIT         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [BIT-1:0]   i_gray,
    input  logic             i_clr_err,
    output logic             o_ready,
    output logic [BIT-1:0]   o_bin,
    output logic             o_valid,
    output logic             o_dir,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    // state | meaning
    // FILL  | synchronizer chain filling after reset, outputs held at 0
    // LOAD  | capture first synchronized sample as the tracking baseline
    // TRACK | compare each sample with the previous one, classify the step
    typedef enum logic [1:0] {FILL, LOAD, TRACK} state_t;

    localparam int FW = $clog2(SYNC_STAGES + 1);
    localparam logic [BIT-1:0]   ONE_B   = BIT'(1);
    localparam logic [ERR_W-1:0] ONE_E   = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state_q;
    logic [FW-1:0]    fill_q;
    logic [BIT-1:0]   sync_q [SYNC_STAGES];
    logic [BIT-1:0]   prev_q;
    logic             ready_q;
    logic [BIT-1:0]   bin_q;
    logic             valid_q;
    logic             dir_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic [BIT-1:0]   s;
    logic [BIT-1:0]   bin_d;
    logic [BIT-1:0]   diff;
    logic             step_any;
    logic             step_multi;

    assign s = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_d = '0;
        for (int k = 0; k < BIT; k++) begin
            bin_d[k] = ^(s >> k);
        end
    end

    assign diff       = s ^ prev_q;
    assign step_any   = |diff;
    assign step_multi = |(diff & (diff - ONE_B));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= FILL;
            fill_q    <= '0;
            prev_q    <= '0;
            ready_q   <= 1'b0;
            bin_q     <= '0;
            valid_q   <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                FILL: begin
                    fill_q <= fill_q + FW'(1);
                    if (fill_q == FW'(SYNC_STAGES - 1)) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    prev_q  <= s;
                    bin_q   <= bin_d;
                    ready_q <= 1'b1;
                    state_q <= TRACK;
                end
                TRACK: begin
                    prev_q <= s;
                    if (step_multi) begin
                        // A clear in the same cycle loses to the new error.
                        bin_q <= bin_d;
                        err_q <= 1'b1;
                        if (i_clr_err) begin
                            err_cnt_q <= ONE_E;
                        end else if (err_cnt_q != ERR_MAX) begin
                            err_cnt_q <= err_cnt_q + ONE_E;
                        end
                    end else begin
                        if (i_clr_err) begin
                            err_q     <= 1'b0;
                            err_cnt_q <= '0;
                        end
                        if (step_any) begin
                            bin_q   <= bin_d;
                            valid_q <= 1'b1;
                            dir_q   <= (bin_d == bin_q + ONE_B);
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_bin     = bin_q;
    assign o_valid   = valid_q;
    assign o_dir     = dir_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_rx_tracker.sv
// Directed-vector bench for gray_rx_tracker with a queue scoreboard for o_valid pulses.
module tb_gray_rx_tracker;

    logic       clk;
    logic       rst;
    logic [7:0] gray;
    logic       clr_err;
    logic       ready;
    logic [7:0] bin;
    logic       valid;
    logic       dir;
    logic       err;
    logic [1:0] err_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] bin;
        logic       dir;
    } exp_t;
    exp_t exp_q[$];

    gray_rx_tracker #(.BIT(8), .SYNC_STAGES(2), .ERR_W(2)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_gray    (gray),
        .i_clr_err (clr_err),
        .o_ready   (ready),
        .o_bin     (bin),
        .o_valid   (valid),
        .o_dir     (dir),
        .o_err     (err),
        .o_err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every o_valid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got o_valid=1 o_bin=%0h expected no pulse at %0t",
                         bin, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("valid_bin", {24'd0, bin}, {24'd0, e.bin});
                chk("valid_dir", {31'd0, dir}, {31'd0, e.dir});
            end
        end
    end

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic drive(input logic [7:0] g);
        @(posedge clk);
        #1 gray = g;
    endtask

    task automatic push(input logic [7:0] b, input logic d);
        exp_t e;
        e.bin = b;
        e.dir = d;
        exp_q.push_back(e);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reload(input logic [7:0] g);
        @(posedge clk);
        #1 rst = 1'b1;
        gray = g;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle(4);
    endtask

    task automatic pulse_clr;
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        gray    = 8'h0C;
        clr_err = 1'b0;

        // Reset and initial load: Gray 0C decodes to 08.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_bin", {24'd0, bin}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", {30'd0, err_cnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_ready_early", {31'd0, ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("init_ready", {31'd0, ready}, 32'd1);
        chk("init_bin", {24'd0, bin}, 32'h08);
        chk("init_err", {31'd0, err}, 32'd0);

        // Up sequence 9..20 with latency check on each step.
        for (int b = 9; b <= 20; b++) begin
            drive(to_gray(8'(b)));
            push(8'(b), 1'b1);
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("up_latency_old", {24'd0, bin}, 32'(b - 1));
            @(posedge clk);
            @(negedge clk);
            chk("up_latency_new", {24'd0, bin}, 32'(b));
            @(posedge clk);
        end

        // Down steps and wrap in both directions.
        reload(8'h01);
        chk("reload01_ready", {31'd0, ready}, 32'd1);
        chk("reload01_bin", {24'd0, bin}, 32'h01);
        drive(8'h00); push(8'h00, 1'b0); settle(4);
        drive(8'h80); push(8'hFF, 1'b0); settle(4);
        chk("wrap_down_bin", {24'd0, bin}, 32'hFF);
        drive(8'h81); push(8'hFE, 1'b0); settle(4);
        drive(8'h80); push(8'hFF, 1'b1); settle(4);
        drive(8'h00); push(8'h00, 1'b1); settle(4);
        chk("wrap_up_bin", {24'd0, bin}, 32'h00);
        chk("wrap_err", {31'd0, err}, 32'd0);

        // Illegal two-bit jump, then a legal step.
        drive(8'h03); settle(4);
        chk("illegal_bin", {24'd0, bin}, 32'h02);
        chk("illegal_err", {31'd0, err}, 32'd1);
        chk("illegal_cnt", {30'd0, err_cnt}, 32'd1);
        chk("illegal_dir_kept", {31'd0, dir}, 32'd1);
        drive(8'h02); push(8'h03, 1'b1); settle(4);
        chk("after_illegal_bin", {24'd0, bin}, 32'h03);

        // Clear, then saturate the 2-bit counter.
        pulse_clr;
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_cnt", {30'd0, err_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? 8'h01 : 8'h02);
            settle(4);
            chk("sat_cnt", {30'd0, err_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
        end
        chk("sat_err", {31'd0, err}, 32'd1);
        chk("sat_bin", {24'd0, bin}, 32'h01);
        pulse_clr;
        chk("clr2_err", {31'd0, err}, 32'd0);
        chk("clr2_cnt", {30'd0, err_cnt}, 32'd0);

        // Clear coinciding with an illegal transition: error wins.
        drive(8'h02);
        repeat (2) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
        chk("clr_vs_err_err", {31'd0, err}, 32'd1);
        chk("clr_vs_err_cnt", {30'd0, err_cnt}, 32'd1);
        chk("clr_vs_err_bin", {24'd0, bin}, 32'h03);

        // Reset mid-operation while tracking 2A.
        drive(to_gray(8'h2A)); settle(4);
        chk("pre_rst_bin", {24'd0, bin}, 32'h2A);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_bin", {24'd0, bin}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_cnt", {30'd0, err_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_ready_early", {31'd0, ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready_back", {31'd0, ready}, 32'd1);
        chk("midrst_bin_back", {24'd0, bin}, 32'h2A);

        settle(6);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
